sa_core_ctrl: RTL and testbench

- Sequencer for the SA_CORE systolic array.
- On a start command it streams K operand vectors from the operand buffer into the core, applying the diagonal input skew. It then drains result vectors into the result buffer and signals done.
- It sits between the host register interface and SA_CORE. It owns the core's inpvalid/outread handshake.

---
 rtl/sa_core_ctrl_pkg.sv | 17 +
 rtl/sa_core_ctrl_if.sv | 39 +++
 rtl/sa_core_ctrl_skew.sv | 42 ++++
 rtl/sa_core_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sa_core_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_core_ctrl_pkg.sv
// Shared types for the SA_CORE sequencer and the array itself.
package sa_pkg;

  localparam int SA_ROWS = 8;

  typedef logic [7:0]  operand_t;
  typedef logic [31:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/sa_core_ctrl_if.sv
// Operand-buffer, SA_CORE and result-buffer bus driven by the sequencer.
interface sa_core_ctrl_if
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int AW   = 8
) ();

  logic                op_rd_en;
  logic [AW-1:0]       op_rd_addr;
  logic [ROWS*8-1:0]   op_a_data;
  logic [ROWS*8-1:0]   op_w_data;
  operand_t [ROWS-1:0] sa_a;
  operand_t [ROWS-1:0] sa_w;
  logic                sa_inpvalid;
  logic                sa_outread;
  acc_t [ROWS-1:0]     sa_rout;
  logic [ROWS-1:0]     sa_rvalid;
  logic                res_wr_en;
  logic [AW-1:0]       res_wr_addr;
  logic [ROWS*32-1:0]  res_wr_data;

  // Handshakes: a result beat transfers in the cycle where all sa_rvalid lanes
  // are high and sa_outread (the ready) is high; sa_outread is never raised
  // without full valid. Operand reads have no backpressure: data for an
  // op_rd_en cycle is on op_a_data/op_w_data exactly one cycle later.
  modport master (
    output op_rd_en, op_rd_addr, sa_a, sa_w, sa_inpvalid, sa_outread,
           res_wr_en, res_wr_addr, res_wr_data,
    input  op_a_data, op_w_data, sa_rout, sa_rvalid
  );

  modport slave (
    input  op_rd_en, op_rd_addr, sa_a, sa_w, sa_inpvalid, sa_outread,
           res_wr_en, res_wr_addr, res_wr_data,
    output op_a_data, op_w_data, sa_rout, sa_rvalid
  );

endinterface

// File: rtl/sa_core_ctrl_skew.sv
// Diagonal input skew: lane r is delayed r cycles and reads 0 outside its valid window.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ROWS-1:0]     in_vld_i,
  input  logic [ROWS*8-1:0]   in_data_i,
  output operand_t [ROWS-1:0] out_data_o,
  output logic [ROWS-1:0]     out_vld_o
);

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    if (r == 0) begin : g_pass
      assign out_vld_o[r]  = in_vld_i[r];
      assign out_data_o[r] = in_vld_i[r] ? in_data_i[r*8 +: 8] : '0;
    end else begin : g_chain
      operand_t       dat_q [r];
      logic [r-1:0]   vld_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int j = 0; j < r; j++) dat_q[j] <= '0;
          vld_q <= '0;
        end else begin
          dat_q[0] <= in_data_i[r*8 +: 8];
          vld_q[0] <= in_vld_i[r];
          for (int j = 1; j < r; j++) begin
            dat_q[j] <= dat_q[j-1];
            vld_q[j] <= vld_q[j-1];
          end
        end
      end

      assign out_vld_o[r]  = vld_q[r-1];
      assign out_data_o[r] = vld_q[r-1] ? dat_q[r-1] : '0;
    end
  end

endmodule

// File: rtl/sa_core_ctrl.sv
// SA_CORE job sequencer: feed K skewed operand vectors, drain result vectors, pulse done.
// Define SA_CTRL_TIMEOUT_EN to add a DRAIN watchdog and the timeout output.
module sa_core_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS        = SA_ROWS,
  parameter int AW          = 8,
  parameter int KW          = 8,
`ifdef SA_CTRL_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 1024,
`endif
  parameter int DRAIN_VECS  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
`ifdef SA_CTRL_TIMEOUT_EN
  output logic              timeout,
`endif
  output ctrl_state_e       dbg_state,
  sa_core_ctrl_if.master    bus
);

  localparam int DCW = (DRAIN_VECS > 1) ? $clog2(DRAIN_VECS) : 1;

  ctrl_state_e      state_q;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    feed_cnt_q;
  logic [DCW-1:0]   drain_cnt_q;
  logic [AW-1:0]    op_rd_addr_q;
  logic             op_rd_en_q;
  logic             ret_vld_q;
  logic             busy_q;
  logic             done_q;
  logic [ROWS-1:0]  a_vld;
  logic [ROWS-1:0]  w_vld;
  logic             accept;

`ifdef SA_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0]   wd_q;
  logic             timeout_q;
  assign timeout = timeout_q;
`endif

  sa_skew_line #(.ROWS(ROWS)) u_skew_a (
    .clk        (clk),
    .rstn       (rstn),
    .in_vld_i   ({ROWS{ret_vld_q}}),
    .in_data_i  (bus.op_a_data),
    .out_data_o (bus.sa_a),
    .out_vld_o  (a_vld)
  );

  sa_skew_line #(.ROWS(ROWS)) u_skew_w (
    .clk        (clk),
    .rstn       (rstn),
    .in_vld_i   ({ROWS{ret_vld_q}}),
    .in_data_i  (bus.op_w_data),
    .out_data_o (bus.sa_w),
    .out_vld_o  (w_vld)
  );

  // The union of the per-lane windows is one contiguous run of K+ROWS-1 cycles.
  assign bus.sa_inpvalid = |(a_vld | w_vld);

  assign accept          = (state_q == DRAIN) && (&bus.sa_rvalid);
  assign bus.sa_outread  = accept;
  assign bus.res_wr_en   = accept;
  assign bus.res_wr_addr = AW'(drain_cnt_q);
  assign bus.res_wr_data = accept ? bus.sa_rout : '0;
  assign bus.op_rd_en    = op_rd_en_q;
  assign bus.op_rd_addr  = op_rd_addr_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      k_q          <= '0;
      feed_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      op_rd_en_q   <= 1'b0;
      op_rd_addr_q <= '0;
      ret_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      ret_vld_q <= op_rd_en_q;
      done_q    <= 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              state_q      <= FEED;
              k_q          <= k_len;
              feed_cnt_q   <= KW'(1);
              op_rd_en_q   <= 1'b1;
              op_rd_addr_q <= '0;
              busy_q       <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        FEED: begin
          // feed_cnt_q counts reads issued including the current one.
          if (feed_cnt_q == k_q) begin
            state_q    <= FLUSH;
            op_rd_en_q <= 1'b0;
          end else begin
            feed_cnt_q   <= feed_cnt_q + KW'(1);
            op_rd_addr_q <= op_rd_addr_q + AW'(1);
          end
        end
        FLUSH: begin
          if (!bus.sa_inpvalid) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
`ifdef SA_CTRL_TIMEOUT_EN
            wd_q        <= '0;
`endif
          end
        end
        DRAIN: begin
          if (accept) begin
            if (drain_cnt_q == DCW'(DRAIN_VECS - 1)) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              drain_cnt_q <= '0;
            end else begin
              drain_cnt_q <= drain_cnt_q + DCW'(1);
            end
`ifdef SA_CTRL_TIMEOUT_EN
            wd_q <= '0;
          end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
            drain_cnt_q <= '0;
          end else begin
            wd_q <= wd_q + WDW'(1);
`endif
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_core_ctrl.sv
// Directed bench for sa_core_ctrl: expectations queued by the drivers, checked by a negedge monitor.
module tb_sa_core_ctrl;
  import sa_pkg::*;

  localparam int ROWS       = 8;
  localparam int AW         = 8;
  localparam int KW         = 8;
  localparam int DRAIN_VECS = 8;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  ctrl_state_e   dbg_state;
`ifdef SA_CTRL_TIMEOUT_EN
  logic          timeout;
`endif

  sa_core_ctrl_if #(.ROWS(ROWS), .AW(AW)) bus ();

  sa_core_ctrl #(
    .ROWS       (ROWS),
    .AW         (AW),
    .KW         (KW),
`ifdef SA_CTRL_TIMEOUT_EN
    .TIMEOUT_CYC(16),
`endif
    .DRAIN_VECS (DRAIN_VECS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
`ifdef SA_CTRL_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int                 n_cmp;
  int                 n_fail;
  int                 job_id;
  logic [AW-1:0]      rd_exp_q[$];
  logic [ROWS*8-1:0]  a_exp_q[$];
  logic [ROWS*8-1:0]  w_exp_q[$];
  int                 run_exp_q[$];
  logic [AW-1:0]      wa_exp_q[$];
  logic [ROWS*32-1:0] wd_exp_q[$];
  logic               done_exp_q[$];

  function automatic logic [ROWS*8-1:0] gen_vec(input bit is_w, input int k);
    logic [ROWS*8-1:0] v;
    int base;
    base = is_w ? 128 : 16;
    for (int r = 0; r < ROWS; r++) v[r*8 +: 8] = 8'(base + 16*k + r);
    return v;
  endfunction

  // Operand buffer: synchronous read, one cycle latency.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.op_a_data <= '0;
      bus.op_w_data <= '0;
    end else if (bus.op_rd_en) begin
      bus.op_a_data <= gen_vec(1'b0, int'(bus.op_rd_addr));
      bus.op_w_data <= gen_vec(1'b1, int'(bus.op_rd_addr));
    end
  end

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    int                 run;
    bit                 done_prev;
    logic [AW-1:0]      ea;
    logic [ROWS*8-1:0]  ev_a;
    logic [ROWS*8-1:0]  ev_w;
    logic [ROWS*32-1:0] ed;
    logic               eto;
    logic               got_to;
    int                 er;
    run = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        run = 0;
        done_prev = 1'b0;
      end else begin
        if (bus.op_rd_en) begin
          if (rd_exp_q.size() == 0) chk("rd_unexpected", {1'b1, bus.op_rd_addr}, 0);
          else begin
            ea = rd_exp_q.pop_front();
            chk("rd_addr", bus.op_rd_addr, ea);
          end
        end
        if (bus.sa_inpvalid) begin
          run++;
          if (a_exp_q.size() == 0) chk("inpvalid_unexpected", 1, 0);
          else begin
            ev_a = a_exp_q.pop_front();
            ev_w = w_exp_q.pop_front();
            chk("sa_a", bus.sa_a, ev_a);
            chk("sa_w", bus.sa_w, ev_w);
          end
        end else begin
          chk("lanes_idle_zero", {bus.sa_a, bus.sa_w}, 0);
          if (run != 0) begin
            er = (run_exp_q.size() != 0) ? run_exp_q.pop_front() : -1;
            chk("inpvalid_len", run, er);
            run = 0;
          end
        end
        if (bus.res_wr_en || bus.sa_outread) begin
          chk("outread_eq_wr", bus.sa_outread, bus.res_wr_en);
          if (wa_exp_q.size() == 0) chk("wr_unexpected", {1'b1, bus.res_wr_addr}, 0);
          else begin
            ea = wa_exp_q.pop_front();
            ed = wd_exp_q.pop_front();
            chk("res_wr_addr", bus.res_wr_addr, ea);
            chk("res_wr_data", bus.res_wr_data, ed);
          end
        end
        if (done_prev) begin
          chk("done_one_cycle", {done, dbg_state}, {1'b0, IDLE});
          done_prev = 1'b0;
        end
        if (done) begin
`ifdef SA_CTRL_TIMEOUT_EN
          got_to = timeout;
`else
          got_to = 1'b0;
`endif
          if (done_exp_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            eto = done_exp_q.pop_front();
            chk("done_busy_timeout", {busy, got_to}, {1'b0, eto});
          end
          done_prev = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_state(input ctrl_state_e s, input int limit);
    int n;
    n = 0;
    while (dbg_state !== s && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_state", dbg_state, s);
  endtask

  task automatic issue_start(input int k);
    logic [ROWS*8-1:0] av, wv, src;
    job_id++;
    if (k == 0) done_exp_q.push_back(1'b0);
    else begin
      for (int i = 0; i < k; i++) rd_exp_q.push_back(AW'(i));
      run_exp_q.push_back(k + ROWS - 1);
      for (int c = 0; c < k + ROWS - 1; c++) begin
        av = '0;
        wv = '0;
        for (int r = 0; r < ROWS; r++) begin
          if (c - r >= 0 && c - r < k) begin
            src = gen_vec(1'b0, c - r);
            av[r*8 +: 8] = src[r*8 +: 8];
            src = gen_vec(1'b1, c - r);
            wv[r*8 +: 8] = src[r*8 +: 8];
          end
        end
        a_exp_q.push_back(av);
        w_exp_q.push_back(wv);
      end
    end
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic drain(input bit gaps);
    int n;
    bit phase;
    logic [ROWS*32-1:0] rv;
    n = 0;
    phase = 1'b0;
    done_exp_q.push_back(1'b0);
    wait_state(DRAIN, 100);
    while (n < DRAIN_VECS) begin
      if (gaps && !phase) begin
        bus.sa_rvalid = 8'hF0;
        bus.sa_rout   = {ROWS{32'hDEAD_BEEF}};
      end else begin
        for (int r = 0; r < ROWS; r++) rv[r*32 +: 32] = 32'(job_id*65536 + (n+1)*256 + r);
        bus.sa_rvalid = '1;
        bus.sa_rout   = rv;
        wa_exp_q.push_back(AW'(n));
        wd_exp_q.push_back(rv);
        n++;
      end
      phase = !phase;
      @(posedge clk); #1;
    end
    bus.sa_rvalid = '0;
    bus.sa_rout   = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    n_cmp  = 0;
    n_fail = 0;
    job_id = 0;
    rstn   = 1'b0;
    start  = 1'b1;
    k_len  = KW'(5);
    bus.sa_rvalid = '0;
    bus.sa_rout   = '0;
    fork
      monitor_loop();
    join_none

    // Reset: start held high while in reset must be ignored.
    #20;
    chk("in_reset", {busy, done, bus.op_rd_en, dbg_state}, {3'b000, IDLE});
    #4 start = 1'b0;
    k_len = '0;
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("reset_ctrl", {busy, done, bus.op_rd_en, bus.op_rd_addr, bus.sa_inpvalid,
                       bus.sa_outread, bus.res_wr_en, bus.res_wr_addr, dbg_state}, {'0, IDLE});
    chk("reset_data", {bus.sa_a, bus.sa_w, bus.res_wr_data}, 0);

    // K=4, then 8 back-to-back accepts.
    issue_start(4);
    chk("busy_after_start", {busy, dbg_state}, {1'b1, FEED});
    drain(1'b0);
    repeat (3) @(posedge clk);
    #1;

    // K=5 with partial-valid gaps; a start during DONE is dropped.
    issue_start(5);
    drain(1'b1);
    chk("in_done_state", dbg_state, DONE);
    start = 1'b1;
    k_len = KW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = '0;
    repeat (4) @(posedge clk);
    #1;

    // K=0: immediate done, no reads.
    issue_start(0);
    repeat (4) @(posedge clk);
    #1;

    // K=3 with a second start mid-FEED carrying a different length.
    issue_start(3);
    start = 1'b1;
    k_len = KW'(9);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = '0;
    drain(1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-FEED aborts: no done, everything cleared.
    issue_start(4);
    @(posedge clk); #1;
    rstn = 1'b0;
    rd_exp_q.delete();
    a_exp_q.delete();
    w_exp_q.delete();
    run_exp_q.delete();
    #2;
    chk("abort_outputs", {busy, done, bus.op_rd_en, bus.sa_inpvalid, bus.sa_a, bus.sa_w, dbg_state},
        {'0, IDLE});
    @(posedge clk); #3;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle", {busy, dbg_state}, {1'b0, IDLE});

`ifdef SA_CTRL_TIMEOUT_EN
    // Watchdog: no rvalid in DRAIN, done+timeout 16 cycles after entry.
    issue_start(1);
    done_exp_q.push_back(1'b1);
    wait_state(DRAIN, 100);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_latency", n, 16);
    repeat (3) @(posedge clk);
    #1;
`else
    n = 0;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("queues_empty", rd_exp_q.size() + a_exp_q.size() + run_exp_q.size() +
        wa_exp_q.size() + done_exp_q.size() + n - n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
